deserializer_8bit: RTL and testbench

Receive-side serial-to-parallel converter for the SerDes link. It shifts in a serial bit stream MSB-first and hunts for a framing sync byte to find byte alignment. Once locked, it emits each 8-bit data word with a one-cycle valid strobe and checks the sync byte at every frame boundary. It sits at the far end of the serial lane and feeds the parallel receive datapath that mirrors the transmit-side 8-bit holding stage.

---
 rtl/deserializer_8bit_if.sv | 29 ++
 rtl/deserializer_8bit.sv | 149 ++++++++++++++
 tb/tb_deserializer_8bit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/deserializer_8bit_if.sv
// Serial receive lane bundle: bit stream in, parallel bytes and link status out.
interface deserializer_8bit_if;
   logic       sdata_in;
   logic       sdata_en;
   logic [7:0] data_8b_out;
   logic       data_valid;
   logic       locked;
   logic       sync_err;

   // Upstream side: drives the serial bits and observes the parallel results.
   modport master (
      output sdata_in,
      output sdata_en,
      input  data_8b_out,
      input  data_valid,
      input  locked,
      input  sync_err
   );

   // Deserializer side.
   modport slave (
      input  sdata_in,
      input  sdata_en,
      output data_8b_out,
      output data_valid,
      output locked,
      output sync_err
   );
endinterface

// File: rtl/deserializer_8bit.sv
// Serial-to-parallel receiver: hunts for a sync byte, then emits FRAME_LEN data
// bytes per frame and verifies the sync byte at each frame boundary.
module deserializer_8bit #(
   parameter logic [7:0] SYNC_WORD = 8'hA5,
   parameter int         FRAME_LEN = 16,
   parameter int         MAX_MISS  = 2
) (
   input logic                clk,
   input logic                rst_n,
   deserializer_8bit_if.slave bus
);

   localparam int BC_W = $clog2(FRAME_LEN + 1);
   localparam int MC_W = $clog2(MAX_MISS + 1);
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(FRAME_LEN - 1);
   localparam logic [MC_W-1:0] MISS_LIM  = MC_W'(MAX_MISS);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      sr_q, sr_d;
   logic [3:0]      fill_q, fill_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            locked_q, locked_d;
   logic            serr_q, serr_d;

   // Window including the bit currently on the line.
   logic [7:0]      w;
   logic [MC_W-1:0] miss_inc;

   assign w        = {sr_q[6:0], bus.sdata_in};
   assign miss_inc = miss_cnt_q + MC_W'(1);

   // State and output registers; reset wins over the bit strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sr_q       <= '0;
         fill_q     <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         miss_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         serr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         fill_q     <= fill_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         serr_q     <= serr_d;
      end
   end

   // Next-state logic: everything holds unless a bit is strobed in; pulses default low.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      fill_d     = fill_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      miss_cnt_d = miss_cnt_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      locked_d   = locked_q;
      serr_d     = 1'b0;

      if (bus.sdata_en) begin
         sr_d = w;
         unique case (state_q)
            HUNT: begin
               if (fill_q != 4'd8) begin
                  fill_d = fill_q + 4'd1;
               end
               // Only a fully populated window may qualify as a sync match.
               if ((fill_q >= 4'd7) && (w == SYNC_WORD)) begin
                  state_d    = DATA;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  fill_d     = '0;
                  locked_d   = 1'b1;
               end
            end

            DATA: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  data_d  = w;
                  valid_d = 1'b1;
                  if (byte_cnt_q == LAST_BYTE) begin
                     state_d    = CHECK;
                     byte_cnt_d = '0;
                  end else begin
                     byte_cnt_d = byte_cnt_q + BC_W'(1);
                  end
               end
            end

            CHECK: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (w == SYNC_WORD) begin
                     miss_cnt_d = '0;
                     state_d    = DATA;
                  end else begin
                     serr_d = 1'b1;
                     if (miss_inc == MISS_LIM) begin
                        // Too many bad boundaries: drop alignment and start hunting afresh.
                        state_d    = HUNT;
                        locked_d   = 1'b0;
                        miss_cnt_d = '0;
                        fill_d     = '0;
                     end else begin
                        miss_cnt_d = miss_inc;
                        state_d    = DATA;
                     end
                  end
               end
            end

            default: begin
               state_d  = HUNT;
               fill_d   = '0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.data_8b_out = data_q;
   assign bus.data_valid  = valid_q;
   assign bus.locked      = locked_q;
   assign bus.sync_err    = serr_q;

endmodule

// File: tb/tb_deserializer_8bit.sv
// Bench for deserializer_8bit: table-driven frame vectors plus hand-written
// corner sequences, with a queue of expected output bytes.
module tb_deserializer_8bit;

   logic clk;
   logic rst_n;

   deserializer_8bit_if bus ();

   deserializer_8bit #(
      .SYNC_WORD (8'hA5),
      .FRAME_LEN (16),
      .MAX_MISS  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic       exp_valid;
      logic       exp_locked;
   } vec_t;

   vec_t       tbl [18];
   logic [7:0] exp_q [$];
   int         checks;
   int         errors;
   int         serr_cnt;
   bit         gap_mode;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock and inspect the registered outputs just after the edge.
   task automatic tick();
      logic en_at_edge;
      logic [7:0] e;
      en_at_edge = bus.sdata_en;
      @(posedge clk);
      #1;
      if (bus.sync_err) serr_cnt++;
      if (bus.data_valid) begin
         if (!en_at_edge || !rst_n) begin
            chk("valid_without_strobe", 32'(bus.data_valid), 32'd0);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(bus.data_8b_out), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("data_byte", 32'(bus.data_8b_out), 32'(e));
         end
      end
   endtask

   task automatic send_bit(input logic b);
      bus.sdata_in = b;
      bus.sdata_en = 1'b1;
      tick();
      if (gap_mode) begin
         bus.sdata_en = 1'b0;
         bus.sdata_in = $urandom_range(0, 1);
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   task automatic send_byte(input logic [7:0] v, input logic expect_out);
      if (expect_out) exp_q.push_back(v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int i = 0; i < 16; i++) send_byte(base + 8'(i), 1'b1);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.sdata_en = 1'b1;
      bus.sdata_in = 1'b1;
      exp_q.delete();
      tick();
      chk("rst_data", 32'(bus.data_8b_out), 32'd0);
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
      rst_n        = 1'b1;
      bus.sdata_en = 1'b0;
      serr_cnt     = 0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 18; i++) begin
         send_byte(tbl[i].din, tbl[i].exp_valid);
         chk({tag, "_locked"}, 32'(bus.locked), 32'(tbl[i].exp_locked));
      end
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_sync_err"}, 32'(serr_cnt), 32'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      serr_cnt     = 0;
      gap_mode     = 1'b0;
      rst_n        = 1'b0;
      bus.sdata_in = 1'b0;
      bus.sdata_en = 1'b0;

      tbl[0] = '{din: 8'hA5, exp_valid: 1'b0, exp_locked: 1'b1};
      for (int i = 1; i <= 16; i++)
         tbl[i] = '{din: 8'(i - 1), exp_valid: 1'b1, exp_locked: 1'b1};
      tbl[17] = '{din: 8'hA5, exp_valid: 1'b0, exp_locked: 1'b1};

      // Basic lock and one full frame, strobe held high.
      do_reset();
      run_table("basic");

      // Same frame with random idle gaps between bits.
      do_reset();
      gap_mode = 1'b1;
      run_table("gapped");
      gap_mode = 1'b0;

      // Lock must land on the sync byte despite three leading stray bits.
      do_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("misalign_prelock", 32'(bus.locked), 32'd0);
      send_byte(8'hA5, 1'b0);
      chk("misalign_locked", 32'(bus.locked), 32'd1);
      send_byte(8'h3C, 1'b1);
      chk("misalign_pending", 32'(exp_q.size()), 32'd0);

      // One bad sync byte: error pulse, alignment kept.
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_frame(8'h00);
      send_byte(8'h5A, 1'b0);
      chk("miss1_sync_err", 32'(serr_cnt), 32'd1);
      chk("miss1_locked", 32'(bus.locked), 32'd1);
      send_frame(8'h10);
      chk("miss1_pending", 32'(exp_q.size()), 32'd0);

      // Two consecutive bad sync bytes drop lock; no data until a new sync.
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_frame(8'h00);
      send_byte(8'h00, 1'b0);
      chk("loss_first_err", 32'(serr_cnt), 32'd1);
      chk("loss_still_locked", 32'(bus.locked), 32'd1);
      send_frame(8'h20);
      send_byte(8'h00, 1'b0);
      chk("loss_second_err", 32'(serr_cnt), 32'd2);
      chk("loss_unlocked", 32'(bus.locked), 32'd0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      chk("loss_hunting", 32'(bus.locked), 32'd0);
      send_byte(8'hA5, 1'b0);
      chk("loss_relocked", 32'(bus.locked), 32'd1);
      send_byte(8'h77, 1'b1);
      chk("loss_pending", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of the third data byte discards it and needs a new sync.
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      chk("midrst_pending", 32'(exp_q.size()), 32'd0);
      do_reset();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      chk("midrst_unlocked", 32'(bus.locked), 32'd0);
      send_byte(8'hA5, 1'b0);
      chk("midrst_relocked", 32'(bus.locked), 32'd1);
      send_byte(8'h55, 1'b1);
      chk("midrst_final_pending", 32'(exp_q.size()), 32'd0);

      bus.sdata_en = 1'b0;
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
